// File: rtl/blake2b_compress_sched.sv
// blake2b_compress_sched: iterative BLAKE2b compression-function scheduler.
// Owns the 16-word working vector, the round/G-call counters and SIGMA, and
// time-multiplexes one external pipelined G datapath over all G calls of a block.
// Optional macro BLAKE2B_SCHED_PERF_EN adds block/stall performance counters.
module blake2b_compress_sched #(
   parameter int unsigned G_LATENCY = 1,
   parameter int unsigned ROUNDS    = 12
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_val,
   output logic          o_rdy,
   input  logic [511:0]  i_h,
   input  logic [1023:0] i_m,
   input  logic [127:0]  i_t,
   input  logic          i_f,
   output logic          o_val,
   input  logic          i_rdy,
   output logic [511:0]  o_h,
   output logic [63:0]   o_g_a,
   output logic [63:0]   o_g_b,
   output logic [63:0]   o_g_c,
   output logic [63:0]   o_g_d,
   output logic [63:0]   o_g_m0,
   output logic [63:0]   o_g_m1,
   output logic          o_g_rdy,
   input  logic [63:0]   i_g_a,
   input  logic [63:0]   i_g_b,
   input  logic [63:0]   i_g_c,
   input  logic [63:0]   i_g_d
`ifdef BLAKE2B_SCHED_PERF_EN
   ,
   output logic [31:0]   o_blk_cnt,
   output logic [31:0]   o_stall_cnt
`endif
);

   localparam int unsigned W  = 64;
   localparam int unsigned RW = 4;
   localparam logic [511:0] IV = 512'h5BE0CD19137E2179_1F83D9ABFB41BD6B_9B05688C2B3E6C1F_510E527FADE682D1_A54FF53A5F1D36F1_3C6EF372FE94F82B_BB67AE8584CAA73B_6A09E667F3BCC908;

   typedef enum logic [2:0] {IDLE, INIT, COL, COL_WAIT, DIAG, DIAG_WAIT, FINAL, DONE} state_t;

   state_t          state, state_n;
   logic [RW-1:0]   round, round_n;
   logic [2:0]      gidx, gidx_n;
   logic [W-1:0]    v [16];
   logic [511:0]    h_q;
   logic [1023:0]   m_q;
   logic [127:0]    t_q;
   logic            f_q;
   logic            issue;
   logic            last_round;
   logic            wb_val;
   logic [2:0]      wb_gidx;
   logic            wait_done;
   logic [15:0]     iss_idx, wb_idx;
   logic [RW-1:0]   rmod;
   logic [63:0]     srow;
   logic [3:0]      sel0, sel1;
   logic [511:0]    hfin;

   // G call j -> {d,c,b,a} vector indices; diagonals rotate the lower 2 bits
   function automatic logic [15:0] g_map(input logic [2:0] j);
      logic [1:0] k, kb, kc, kd;
      k  = j[1:0];
      kb = k + {1'b0, j[2]};
      kc = k + {j[2], 1'b0};
      kd = k + {j[2], j[2]};
      return {2'b11, kd, 2'b10, kc, 2'b01, kb, 2'b00, k};
   endfunction

   // SIGMA row r, entry p packed at bits [4p +: 4]
   function automatic logic [63:0] sigma_row(input logic [RW-1:0] r);
      case (r)
         4'd0:    return 64'hFEDCBA9876543210;
         4'd1:    return 64'h357B20C16DF984AE;
         4'd2:    return 64'h491763EADF250C8B;
         4'd3:    return 64'h8F04A562EBCD1397;
         4'd4:    return 64'hD386CB1EFA427509;
         4'd5:    return 64'h91EF57D438B0A6C2;
         4'd6:    return 64'hB8293670A4DEF15C;
         4'd7:    return 64'hA2684F05931CE7BD;
         4'd8:    return 64'h5A417D2C803B9EF6;
         4'd9:    return 64'h0DC3E9BF5167482A;
         default: return 64'hFEDCBA9876543210;
      endcase
   endfunction

   assign issue      = (state == COL) || (state == DIAG);
   assign last_round = (round == RW'(ROUNDS - 1));
   assign rmod       = (round >= 4'd10) ? round - 4'd10 : round;
   assign srow       = sigma_row(rmod);
   assign sel0       = srow[{gidx, 3'b000} +: 4];
   assign sel1       = srow[{gidx, 3'b100} +: 4];
   assign iss_idx    = g_map(gidx);
   assign wb_idx     = g_map(wb_gidx);

   // Writeback tracking: {valid, call index} delayed by the G pipeline depth
   generate
      if (G_LATENCY == 0) begin : g_wb0
         assign wb_val    = issue;
         assign wb_gidx   = gidx;
         assign wait_done = 1'b1;
      end else begin : g_wbn
         logic       pv [G_LATENCY];
         logic [2:0] pj [G_LATENCY];
         logic       early;
         // shift issue tags alongside the G pipeline
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               for (int i = 0; i < int'(G_LATENCY); i++) begin
                  pv[i] <= 1'b0;
                  pj[i] <= 3'd0;
               end
            end else begin
               pv[0] <= issue;
               pj[0] <= gidx;
               for (int i = 1; i < int'(G_LATENCY); i++) begin
                  pv[i] <= pv[i-1];
                  pj[i] <= pj[i-1];
               end
            end
         end
         // any call still in flight behind the one returning now
         always_comb begin
            early = 1'b0;
            for (int i = 0; i < int'(G_LATENCY) - 1; i++) early = early | pv[i];
         end
         assign wb_val    = pv[G_LATENCY-1];
         assign wb_gidx   = pj[G_LATENCY-1];
         assign wait_done = wb_val & ~early;
      end
   endgenerate

   // Next-state and counter logic
   always_comb begin
      state_n = state;
      round_n = round;
      gidx_n  = gidx;
      case (state)
         IDLE:     if (i_val) state_n = INIT;
         INIT: begin
            state_n = COL;
            round_n = '0;
            gidx_n  = '0;
         end
         COL: begin
            gidx_n = gidx + 3'd1;
            if (gidx == 3'd3) state_n = (G_LATENCY == 0) ? DIAG : COL_WAIT;
         end
         COL_WAIT: if (wait_done) state_n = DIAG;
         DIAG: begin
            gidx_n = gidx + 3'd1;
            if (gidx == 3'd7) begin
               if (G_LATENCY != 0)  state_n = DIAG_WAIT;
               else if (last_round) state_n = FINAL;
               else begin
                  state_n = COL;
                  round_n = round + 4'd1;
               end
            end
         end
         DIAG_WAIT: begin
            if (wait_done) begin
               if (last_round) state_n = FINAL;
               else begin
                  state_n = COL;
                  round_n = round + 4'd1;
               end
            end
         end
         FINAL:    state_n = DONE;
         DONE:     if (i_rdy) state_n = IDLE;
         default:  state_n = IDLE;
      endcase
   end

   // Operand issue: zero in cycles with no G call
   always_comb begin
      o_g_a  = '0;
      o_g_b  = '0;
      o_g_c  = '0;
      o_g_d  = '0;
      o_g_m0 = '0;
      o_g_m1 = '0;
      if (issue) begin
         o_g_a  = v[iss_idx[3:0]];
         o_g_b  = v[iss_idx[7:4]];
         o_g_c  = v[iss_idx[11:8]];
         o_g_d  = v[iss_idx[15:12]];
         o_g_m0 = m_q[{sel0, 6'b0} +: 64];
         o_g_m1 = m_q[{sel1, 6'b0} +: 64];
      end
   end

   // Finalisation h ^ v_low ^ v_high
   always_comb begin
      hfin = '0;
      for (int i = 0; i < 8; i++) hfin[64*i +: 64] = h_q[64*i +: 64] ^ v[i] ^ v[i+8];
   end

   // State, counters, registered outputs and block capture
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         round   <= '0;
         gidx    <= '0;
         o_rdy   <= 1'b1;
         o_val   <= 1'b0;
         o_g_rdy <= 1'b0;
         o_h     <= '0;
         h_q     <= '0;
         m_q     <= '0;
         t_q     <= '0;
         f_q     <= 1'b0;
      end else begin
         state   <= state_n;
         round   <= round_n;
         gidx    <= gidx_n;
         o_rdy   <= (state_n == IDLE);
         o_val   <= (state_n == DONE);
         o_g_rdy <= state_n inside {COL, COL_WAIT, DIAG, DIAG_WAIT, FINAL};
         if (state == FINAL) o_h <= hfin;
         if (state == IDLE && i_val) begin
            h_q <= i_h;
            m_q <= i_m;
            t_q <= i_t;
            f_q <= i_f;
         end
      end
   end

   // Working vector: initialise in INIT, then take G results on writeback
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < 16; i++) v[i] <= '0;
      end else if (state == INIT) begin
         for (int i = 0; i < 8; i++) begin
            v[i]   <= h_q[64*i +: 64];
            v[i+8] <= IV[64*i +: 64];
         end
         v[12] <= IV[4*64 +: 64] ^ t_q[63:0];
         v[13] <= IV[5*64 +: 64] ^ t_q[127:64];
         v[14] <= f_q ? ~IV[6*64 +: 64] : IV[6*64 +: 64];
      end else if (wb_val) begin
         v[wb_idx[3:0]]   <= i_g_a;
         v[wb_idx[7:4]]   <= i_g_b;
         v[wb_idx[11:8]]  <= i_g_c;
         v[wb_idx[15:12]] <= i_g_d;
      end
   end

`ifdef BLAKE2B_SCHED_PERF_EN
   // Completed-block (wrapping) and DONE-stall (saturating) counters
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_blk_cnt   <= '0;
         o_stall_cnt <= '0;
      end else begin
         if (o_val && i_rdy) o_blk_cnt <= o_blk_cnt + 32'd1;
         if (state == DONE && !i_rdy && o_stall_cnt != 32'hFFFF_FFFF)
            o_stall_cnt <= o_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_blake2b_compress_sched.sv
// tb_blake2b_compress_sched: directed checks of the BLAKE2b scheduler using a
// behavioural G datapath at latencies 1, 0, 2 and 4 plus a software reference.
`timescale 1ns/1ps
module tb_blake2b_compress_sched;

   localparam int NI = 4;
   localparam logic [511:0] IV = 512'h5BE0CD19137E2179_1F83D9ABFB41BD6B_9B05688C2B3E6C1F_510E527FADE682D1_A54FF53A5F1D36F1_3C6EF372FE94F82B_BB67AE8584CAA73B_6A09E667F3BCC908;
   localparam logic [511:0] ABC_DIGEST = 512'h239900D4ED8623B9_5A92F1DBA88AD318_95CC3345DED552C2_2D79AB2A39C5877D_D1A2FFDB6FBB124B_B7C45A68142F214C_E9F6129FB697276A_0D4D1C983FA580BA;
   localparam logic [511:0]  H_ABC = IV ^ 512'h01010040;
   localparam logic [1023:0] M_ABC = 1024'h636261;
   localparam int SIG [10][16] = '{
      '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
      '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
      '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
      '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
      '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
      '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
      '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
      '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
      '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
      '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}};
   localparam int GI [8][4] = '{
      '{0, 4,  8, 12}, '{1, 5,  9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
      '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7,  8, 13}, '{3, 4,  9, 14}};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [511:0]  h_in;
   logic [1023:0] m_in;
   logic [127:0]  t_in;
   logic          f_in;
   logic          val    [NI];
   logic          rdy_dn [NI];
   logic          rdy_up [NI];
   logic          ov     [NI];
   logic [511:0]  oh     [NI];
   logic          grdy   [NI];
   logic [63:0]   ga [NI], gb [NI], gc [NI], gd [NI], gm0 [NI], gm1 [NI];
   logic [63:0]   ra [NI], rb [NI], rc [NI], rd [NI];
`ifdef BLAKE2B_SCHED_PERF_EN
   logic [31:0]   blk_cnt [NI], stall_cnt [NI];
`endif

   int checks = 0;
   int errors = 0;

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // Mixing function G; returns {d,c,b,a}
   function automatic logic [255:0] g_fn(input logic [63:0] a, b, c, d, x, y);
      a = a + b + x;  d = rotr(d ^ a, 32);
      c = c + d;      b = rotr(b ^ c, 24);
      a = a + b + y;  d = rotr(d ^ a, 16);
      c = c + d;      b = rotr(b ^ c, 63);
      return {d, c, b, a};
   endfunction

   // Software BLAKE2b compression F
   function automatic logic [511:0] ref_compress(input logic [511:0] h, input logic [1023:0] m,
                                                 input logic [127:0] t, input logic f);
      logic [63:0]  v [16];
      logic [255:0] r;
      logic [511:0] out;
      for (int i = 0; i < 8; i++) begin
         v[i]   = h[64*i +: 64];
         v[i+8] = IV[64*i +: 64];
      end
      v[12] = v[12] ^ t[63:0];
      v[13] = v[13] ^ t[127:64];
      if (f) v[14] = ~v[14];
      for (int rr = 0; rr < 12; rr++) begin
         for (int j = 0; j < 8; j++) begin
            r = g_fn(v[GI[j][0]], v[GI[j][1]], v[GI[j][2]], v[GI[j][3]],
                     m[64*SIG[rr%10][2*j] +: 64], m[64*SIG[rr%10][2*j+1] +: 64]);
            v[GI[j][0]] = r[63:0];
            v[GI[j][1]] = r[127:64];
            v[GI[j][2]] = r[191:128];
            v[GI[j][3]] = r[255:192];
         end
      end
      for (int i = 0; i < 8; i++) out[64*i +: 64] = h[64*i +: 64] ^ v[i] ^ v[i+8];
      return out;
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      localparam int unsigned LAT = (gi == 0) ? 1 : (gi == 1) ? 0 : (gi == 2) ? 2 : 4;
      logic [255:0] gres;
      assign gres = g_fn(ga[gi], gb[gi], gc[gi], gd[gi], gm0[gi], gm1[gi]);
      if (LAT == 0) begin : g_comb
         assign {rd[gi], rc[gi], rb[gi], ra[gi]} = gres;
      end else begin : g_pipe
         logic [255:0] pipe [LAT];
         always @(posedge clk) begin
            if (grdy[gi]) begin
               pipe[0] <= gres;
               for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
            end
         end
         assign {rd[gi], rc[gi], rb[gi], ra[gi]} = pipe[LAT-1];
      end

      blake2b_compress_sched #(.G_LATENCY(LAT), .ROUNDS(12)) dut (
         .i_clk   (clk),
         .i_rst   (rst),
         .i_val   (val[gi]),
         .o_rdy   (rdy_up[gi]),
         .i_h     (h_in),
         .i_m     (m_in),
         .i_t     (t_in),
         .i_f     (f_in),
         .o_val   (ov[gi]),
         .i_rdy   (rdy_dn[gi]),
         .o_h     (oh[gi]),
         .o_g_a   (ga[gi]),
         .o_g_b   (gb[gi]),
         .o_g_c   (gc[gi]),
         .o_g_d   (gd[gi]),
         .o_g_m0  (gm0[gi]),
         .o_g_m1  (gm1[gi]),
         .o_g_rdy (grdy[gi]),
         .i_g_a   (ra[gi]),
         .i_g_b   (rb[gi]),
         .i_g_c   (rc[gi]),
         .i_g_d   (rd[gi])
`ifdef BLAKE2B_SCHED_PERF_EN
         ,
         .o_blk_cnt   (blk_cnt[gi]),
         .o_stall_cnt (stall_cnt[gi])
`endif
      );
   end

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for o_val of one instance; n = edges since the accept edge
   task automatic wait_val(input int inst, output int n);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!ov[inst] && n < 400);
      chk("wait_val_timeout", 512'(ov[inst]), 512'(1));
   endtask

   // Present one block to instance 0 and wait for its result
   task automatic run_block(input logic [511:0] h, input logic [1023:0] m,
                            input logic [127:0] t, input logic f, output int n);
      @(negedge clk);
      h_in = h; m_in = m; t_in = t; f_in = f;
      val[0] = 1'b1;
      @(posedge clk);
      #1 val[0] = 1'b0;
      wait_val(0, n);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat [NI];
      int n;
      logic [511:0]  hold, h1ref, href;
      logic [1023:0] m1, m2;
      logic          seen;

      rst = 1'b1; h_in = '0; m_in = '0; t_in = '0; f_in = 1'b0;
      for (int i = 0; i < NI; i++) begin
         val[i] = 1'b0;
         rdy_dn[i] = 1'b1;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_o_rdy",   512'(rdy_up[0]), 512'(1));
      chk("rst_o_val",   512'(ov[0]),     512'(0));
      chk("rst_o_h",     oh[0],           '0);
      chk("rst_o_g_rdy", 512'(grdy[0]),   512'(0));
      chk("rst_o_g_a",   512'(ga[0]),     '0);
      chk("rst_o_g_m0",  512'(gm0[0]),    '0);
      rst = 1'b0;
      @(negedge clk);

      // "abc" on all four G latencies at once
      h_in = H_ABC; m_in = M_ABC; t_in = 128'd3; f_in = 1'b1;
      for (int i = 0; i < NI; i++) begin
         val[i] = 1'b1;
         lat[i] = -1;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) val[i] = 1'b0;
      chk("accept_o_rdy_low", 512'(rdy_up[0]), 512'(0));
      for (int c = 1; c <= 250; c++) begin
         @(posedge clk);
         @(negedge clk);
         for (int i = 0; i < NI; i++) if (ov[i] && lat[i] < 0) lat[i] = c;
      end
      chk("lat_g1", 512'(lat[0]), 512'(122));
      chk("lat_g0", 512'(lat[1]), 512'(98));
      chk("lat_g2", 512'(lat[2]), 512'(146));
      chk("lat_g4", 512'(lat[3]), 512'(194));
      chk("abc_word0_g1", 512'(oh[0][63:0]), 512'(64'h0D4D1C983FA580BA));
      chk("abc_g1", oh[0], ABC_DIGEST);
      chk("abc_g0", oh[1], ABC_DIGEST);
      chk("abc_g2", oh[2], ABC_DIGEST);
      chk("abc_g4", oh[3], ABC_DIGEST);
      chk("abc_model", oh[0], ref_compress(H_ABC, M_ABC, 128'd3, 1'b1));
      chk("idle_o_rdy", 512'(rdy_up[0]), 512'(1));
      chk("idle_o_val", 512'(ov[0]),     512'(0));

      // Backpressure: hold i_rdy low 50 cycles, with a new i_val pending
      rdy_dn[0] = 1'b0;
      run_block(H_ABC, M_ABC, 128'd3, 1'b1, n);
      chk("bp_lat", 512'(n), 512'(122));
      hold = oh[0];
      chk("bp_digest", hold, ABC_DIGEST);
      val[0] = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("bp_o_h_stable", oh[0], hold);
         chk("bp_o_rdy_low",  512'(rdy_up[0]), 512'(0));
         chk("bp_o_val_high", 512'(ov[0]),     512'(1));
      end
      rdy_dn[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_o_val", 512'(ov[0]),     512'(0));
      chk("bp_release_o_rdy", 512'(rdy_up[0]), 512'(1));
      @(posedge clk);
      #1 val[0] = 1'b0;
      chk("bp_new_accept", 512'(rdy_up[0]), 512'(0));

      // Reset in round 5 of the block just accepted
      repeat (55) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_o_val",   512'(ov[0]),     512'(0));
      chk("midrst_o_rdy",   512'(rdy_up[0]), 512'(1));
      chk("midrst_o_h",     oh[0],           '0);
      chk("midrst_o_g_rdy", 512'(grdy[0]),   512'(0));
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (200) begin
         @(negedge clk);
         if (ov[0]) seen = 1'b1;
      end
      chk("midrst_no_o_val", 512'(seen), 512'(0));
      run_block(H_ABC, M_ABC, 128'd3, 1'b1, n);
      chk("post_rst_lat", 512'(n), 512'(122));
      chk("post_rst_abc", oh[0], ABC_DIGEST);

      // Two-block message of bytes 0x00..0xC7
      m1 = '0;
      m2 = '0;
      for (int k = 0; k < 128; k++) m1[8*k +: 8] = 8'(k);
      for (int k = 0; k < 72; k++)  m2[8*k +: 8] = 8'(128 + k);
      h1ref = ref_compress(H_ABC, m1, 128'd128, 1'b0);
      href  = ref_compress(h1ref, m2, 128'd200, 1'b1);
      run_block(H_ABC, m1, 128'd128, 1'b0, n);
      chk("two_block_1", oh[0], h1ref);
      run_block(h1ref, m2, 128'd200, 1'b1, n);
      chk("two_block_2", oh[0], href);

`ifdef BLAKE2B_SCHED_PERF_EN
      // Three blocks with ten DONE stall cycles each
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int b = 0; b < 3; b++) begin
         rdy_dn[0] = 1'b0;
         run_block(H_ABC, M_ABC, 128'd3, 1'b1, n);
         repeat (10) @(posedge clk);
         @(negedge clk);
         rdy_dn[0] = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      chk("perf_blk_cnt",   512'(blk_cnt[0]),   512'(3));
      chk("perf_stall_cnt", 512'(stall_cnt[0]), 512'(30));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
